// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port among icache/dcache of two cores, dcache first.
// Define RAM_ARB_RR_EN for round-robin core tie-break; otherwise core 0 always wins ties.
module ram_arbiter #(
    parameter int WORD_W = 32
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [1:0]             iREN,
    input  logic [1:0][WORD_W-1:0] iaddr,
    output logic [1:0]             iwait,
    output logic [1:0][WORD_W-1:0] iload,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][WORD_W-1:0] daddr,
    input  logic [1:0][WORD_W-1:0] dstore,
    output logic [1:0]             dwait,
    output logic [1:0][WORD_W-1:0] dload,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [WORD_W-1:0]      ramaddr,
    output logic [WORD_W-1:0]      ramstore,
    input  logic [WORD_W-1:0]      ramload,
    input  logic                   ramready
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     r_state;
    logic       r_cls;
    logic       r_core;
    logic [1:0] w_dp;
    logic [1:0] w_pend;
    logic       w_cls;
    logic       w_tie_core;
    logic       w_core;
    logic       w_en;
    logic       w_act;
    logic       w_done;

    assign w_dp   = dREN | dWEN;
    assign w_cls  = ~|w_dp;
    assign w_pend = w_cls ? iREN : w_dp;

`ifdef RAM_ARB_RR_EN
    logic r_last;
    assign w_tie_core = ~r_last;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            r_last <= 1'b1;
        else if (w_done)
            r_last <= r_core;
    end
`else
    assign w_tie_core = 1'b0;
`endif

    assign w_core = &w_pend ? w_tie_core : w_pend[1];

    // r_cls: 0 = dcache, 1 = icache. Enables dropping mid-grant abort the access.
    assign w_en     = r_cls ? iREN[r_core] : (dREN[r_core] | dWEN[r_core]);
    assign w_act    = (r_state == GRANT) && w_en;
    assign ramWEN   = w_act && !r_cls && dWEN[r_core];
    assign ramREN   = w_act && !ramWEN;
    assign ramaddr  = w_act ? (r_cls ? iaddr[r_core] : daddr[r_core]) : '0;
    assign ramstore = (w_act && !r_cls) ? dstore[r_core] : '0;

    assign w_done = (r_state == GRANT) && ramready;
    assign iwait  = ~({2{w_done & r_cls}} & {r_core, ~r_core});
    assign dwait  = ~({2{w_done & ~r_cls}} & {r_core, ~r_core});
    assign iload  = {2{ramload}};
    assign dload  = {2{ramload}};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_cls   <= 1'b0;
            r_core  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (|w_pend) begin
                r_state <= GRANT;
                r_cls   <= w_cls;
                r_core  <= w_core;
            end
        end else if (ramready || !w_en) begin
            r_state <= IDLE;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random traffic against a transaction-level arbiter model.
module tb_ram_arbiter;
    logic             CLK = 0;
    logic             nRST = 0;
    logic [1:0]       iREN = 0, dREN = 0, dWEN = 0;
    logic [1:0][31:0] iaddr = 0, daddr = 0, dstore = 0;
    logic [1:0]       iwait, dwait;
    logic [1:0][31:0] iload, dload;
    logic             ramREN, ramWEN, ramready = 0;
    logic [31:0]      ramaddr, ramstore, ramload = 0;

    int total = 0, bad = 0;
    bit m_busy = 0;
    int m_gnt = 0;
    int m_last = 1;
    logic [1:0] e_iw = 2'b11, e_dw = 2'b11;

`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1;
`else
    localparam bit RR = 0;
`endif

    ram_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Winner core among a pending pair: a tie goes to the core that did not finish last.
    function automatic int pick(input logic [1:0] p);
        if (p == 2'b11) return RR ? 1 - m_last : 0;
        return p[1] ? 1 : 0;
    endfunction

    // Called at negedge with inputs set; checks this cycle and advances the model over the edge.
    task automatic step();
        logic e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        bit nb, en, isd;
        int ng, nl, c;
        logic [1:0] dp;
        #1;
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        e_iw = 2'b11; e_dw = 2'b11;
        nb = m_busy; ng = m_gnt; nl = m_last;
        dp = dREN | dWEN;
        if (m_busy) begin
            c = m_gnt % 2;
            isd = m_gnt < 2;
            en = isd ? (dREN[c] | dWEN[c]) : iREN[c];
            if (!en) nb = 0;
            else begin
                if (isd) begin
                    e_wen = dWEN[c]; e_ren = !dWEN[c]; e_addr = daddr[c]; e_store = dstore[c];
                end else begin
                    e_ren = 1; e_addr = iaddr[c];
                end
                if (ramready) begin
                    if (isd) e_dw[c] = 0; else e_iw[c] = 0;
                    nb = 0; nl = c;
                end
            end
        end else if (dp != 0) begin
            nb = 1; ng = pick(dp);
        end else if (iREN != 0) begin
            nb = 1; ng = 2 + pick(iREN);
        end
        chk("ramREN", ramREN, e_ren);
        chk("ramWEN", ramWEN, e_wen);
        chk("ramaddr", ramaddr, e_addr);
        chk("ramstore", ramstore, e_store);
        chk("iwait", iwait, e_iw);
        chk("dwait", dwait, e_dw);
        chk("iload", iload, {ramload, ramload});
        chk("dload", dload, {ramload, ramload});
        @(posedge CLK);
        m_busy = nb; m_gnt = ng; m_last = nl;
        @(negedge CLK);
    endtask

    task automatic chk_reset();
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_iwait", iwait, 2'b11);
        chk("rst_dwait", dwait, 2'b11);
        m_busy = 0; m_last = 1; e_iw = 2'b11; e_dw = 2'b11;
    endtask

    task automatic drive_rand();
        int c;
        for (int k = 0; k < 2; k++) begin
            if (iREN[k] && (!e_iw[k] || $urandom_range(39) == 0)) iREN[k] = 0;
            if (!iREN[k] && $urandom_range(2) == 0) begin
                iREN[k] = 1; iaddr[k] = $urandom;
            end
            if ((dREN[k] | dWEN[k]) && (!e_dw[k] || $urandom_range(39) == 0)) begin
                dREN[k] = 0; dWEN[k] = 0;
            end
            if (!(dREN[k] | dWEN[k]) && $urandom_range(2) == 0) begin
                c = $urandom_range(2);
                dREN[k] = c != 1; dWEN[k] = c != 0;
                daddr[k] = $urandom; dstore[k] = $urandom;
            end
        end
        ramload = $urandom;
        ramready = $urandom_range(1);
        if (m_busy) begin
            c = m_gnt % 2;
            if (m_gnt < 2 ? !(dREN[c] | dWEN[c]) : !iREN[c]) ramready = 0;
        end
    endtask

    initial begin
        #2 chk_reset();
        @(negedge CLK) nRST = 1;
        // Single icache read
        iREN[0] = 1; iaddr[0] = 32'h40; ramready = 1; ramload = 32'hDEADBEEF;
        step(); step();
        iREN[0] = 0; step();
        // Dcache write beats icache read
        iREN[0] = 1; iaddr[0] = 32'h44; dWEN[1] = 1; daddr[1] = 32'h80; dstore[1] = 32'h1234;
        step(); step();
        dWEN[1] = 0; step(); step();
        iREN[0] = 0; step();
        // Dcache read tie held continuously
        dREN = 2'b11; daddr[0] = 32'h100; daddr[1] = 32'h200;
        repeat (8) step();
        dREN = 0; step();
        // Read and write both high
        dREN[0] = 1; dWEN[0] = 1; dstore[0] = 32'h55;
        step(); step();
        dREN[0] = 0; dWEN[0] = 0; step();
        // Abort before ready
        iREN[0] = 1; ramready = 0;
        step(); step();
        iREN[0] = 0; step(); step();
        // Random traffic with occasional reset during a grant
        for (int n = 0; n < 3000; n++) begin
            drive_rand();
            if (n % 400 == 399 && m_busy) begin
                #1 nRST = 0;
                #1 chk_reset();
                @(posedge CLK);
                @(negedge CLK) nRST = 1;
            end else
                step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
